// File: rtl/button_event_arbiter.sv
// Push-button front end: 2-FF sync, shared-timer debounce, rising-edge
// detect and round-robin serialization of press events over valid/ready.

module synchronizer #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      r_meta <= i_d;
      r_sync <= r_meta;
   end

   assign o_q = r_sync;

endmodule

module button_event_arbiter #(
   parameter int NUM_BTNS       = 4,
   parameter int SAMPLE_CNT_MAX = 25000,
   parameter int PULSE_CNT_MAX  = 150,
   localparam int IDW = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [IDW-1:0]      evt_id,
   output logic                evt_dropped
);

   localparam int TW = $clog2(SAMPLE_CNT_MAX);
   localparam int CW = $clog2(PULSE_CNT_MAX + 1);

   typedef enum logic {
      S_IDLE,
      S_OFFER
   } state_t;

   logic [NUM_BTNS-1:0] w_sync;
   logic [TW-1:0]       r_sample_cnt;
   logic                w_sample_pulse;
   logic [CW-1:0]       r_cnt [NUM_BTNS];
   logic [NUM_BTNS-1:0] r_btn_level;
   logic [NUM_BTNS-1:0] r_prev_level;
   logic [NUM_BTNS-1:0] w_rise;
   logic [NUM_BTNS-1:0] r_pending;
   logic [NUM_BTNS-1:0] w_grant;
   logic                r_dropped;
   state_t              r_state;
   logic [IDW-1:0]      r_rr_ptr;
   logic [IDW-1:0]      r_evt_id;
   logic                r_evt_valid;
   logic                w_found;
   logic [IDW-1:0]      w_grant_idx;
   logic [IDW-1:0]      w_scan;
   logic [IDW-1:0]      w_rr_next;

   synchronizer #(
      .WIDTH(NUM_BTNS)
   ) u_sync (
      .i_clk(clk),
      .i_d  (btn_in),
      .o_q  (w_sync)
   );

   assign w_sample_pulse = (r_sample_cnt == TW'(SAMPLE_CNT_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample_cnt <= '0;
      end else if (w_sample_pulse) begin
         r_sample_cnt <= '0;
      end else begin
         r_sample_cnt <= r_sample_cnt + TW'(1);
      end
   end

   // Counters only move on sample ticks; level tracks saturation a cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            r_cnt[i] <= '0;
         end
         r_btn_level  <= '0;
         r_prev_level <= '0;
      end else begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            if (w_sample_pulse) begin
               if (!w_sync[i]) begin
                  r_cnt[i] <= '0;
               end else if (r_cnt[i] != CW'(PULSE_CNT_MAX)) begin
                  r_cnt[i] <= r_cnt[i] + CW'(1);
               end
            end
            r_btn_level[i] <= (r_cnt[i] == CW'(PULSE_CNT_MAX));
         end
         r_prev_level <= r_btn_level;
      end
   end

   assign w_rise = r_btn_level & ~r_prev_level;

   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      for (int k = 0; k < NUM_BTNS; k++) begin
         w_scan = IDW'((int'(r_rr_ptr) + k) % NUM_BTNS);
         if (!w_found && r_pending[w_scan]) begin
            w_found     = 1'b1;
            w_grant_idx = w_scan;
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (r_state == S_IDLE && w_found) begin
         w_grant[w_grant_idx] = 1'b1;
      end
   end

   // A fresh rise beats a same-cycle grant so the press is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_dropped <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_grant) | w_rise;
         r_dropped <= |(w_rise & r_pending & ~w_grant);
      end
   end

   assign w_rr_next = (r_evt_id == IDW'(NUM_BTNS - 1)) ?
                      '0 : r_evt_id + IDW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_rr_ptr    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_evt_id    <= w_grant_idx;
                  r_evt_valid <= 1'b1;
                  r_state     <= S_OFFER;
               end
            end
            S_OFFER: begin
               if (evt_ready) begin
                  r_rr_ptr    <= w_rr_next;
                  r_evt_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign btn_level   = r_btn_level;
   assign evt_valid   = r_evt_valid;
   assign evt_id      = r_evt_id;
   assign evt_dropped = r_dropped;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: vector table of presses plus
// hand sequences, with an expected-event queue checked at handshakes.
`timescale 1ns/1ps

module tb_button_event_arbiter;

   localparam int N    = 4;
   localparam int SMAX = 4;
   localparam int PMAX = 3;

   typedef struct {
      logic [3:0]      mask;
      int              n;
      logic [3:0][1:0] ids;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_in = '0;
   logic       evt_ready = 1'b0;
   logic [3:0] btn_level;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_dropped;

   int n_checks = 0;
   int n_fail   = 0;
   int n_evt    = 0;
   int n_drop   = 0;
   int n_pushed = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   button_event_arbiter #(
      .NUM_BTNS      (N),
      .SAMPLE_CNT_MAX(SMAX),
      .PULSE_CNT_MAX (PMAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_dropped(evt_dropped)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(logic [1:0] id);
      exp_q.push_back(id);
      n_pushed++;
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      cyc(3);
      rst = 1'b0;
   endtask

   task automatic wait_empty(string name, int max);
      int k = 0;
      while (exp_q.size() != 0 && k < max) begin
         @(negedge clk);
         k++;
      end
      check(name, exp_q.size(), 0);
      cyc(1);
   endtask

   task automatic wait_valid(string name, int max);
      int k = 0;
      @(negedge clk);
      while (!evt_valid && k < max) begin
         @(negedge clk);
         k++;
      end
      check(name, evt_valid, 1);
   endtask

   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         n_evt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got id %0d expected none",
                     evt_id);
         end else begin
            check("evt_id", evt_id, exp_q.pop_front());
         end
      end
      if (!rst && evt_dropped) n_drop++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int   d0;
      tbl[0] = '{4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
      tbl[1] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
      tbl[2] = '{4'b0011, 2, {2'd0, 2'd0, 2'd0, 2'd1}};
      tbl[3] = '{4'b1111, 4, {2'd0, 2'd3, 2'd2, 2'd1}};
      tbl[4] = '{4'b0000, 0, {2'd0, 2'd0, 2'd0, 2'd0}};
      tbl[5] = '{4'b0010, 1, {2'd0, 2'd0, 2'd0, 2'd1}};

      // Held press from reset, exact latency
      btn_in    = 4'b0100;
      evt_ready = 1'b1;
      cyc(3);
      check("rst_level", btn_level, 0);
      check("rst_valid", evt_valid, 0);
      check("rst_id", evt_id, 0);
      check("rst_dropped", evt_dropped, 0);
      push(2'd2);
      rst = 1'b0;
      cyc(12);
      check("t1_level_before", btn_level, 4'b0000);
      cyc(1);
      check("t1_level_rise", btn_level, 4'b0100);
      cyc(1);
      check("t1_valid_early", evt_valid, 0);
      cyc(1);
      check("t1_valid", evt_valid, 1);
      check("t1_id", evt_id, 2);
      cyc(100);
      check("t1_one_event", n_evt, 1);
      check("t1_level_held", btn_level, 4'b0100);
      btn_in = '0;
      cyc(20);
      check("t1_release", btn_level, 4'b0000);
      check("t1_no_release_evt", n_evt, 1);

      // Glitch spanning only two sample ticks
      btn_in = 4'b0010;
      for (int i = 0; i < 30; i++) begin
         if (i == 8) btn_in = '0;
         cyc(1);
         check("t2_level", btn_level, 4'b0000);
         check("t2_valid", evt_valid, 0);
      end

      // Vector table, always ready
      btn_in = '0;
      do_reset();
      for (int v = 0; v < 6; v++) begin
         for (int j = 0; j < tbl[v].n; j++) push(tbl[v].ids[j]);
         btn_in = tbl[v].mask;
         cyc(30);
         check("tbl_level", btn_level, tbl[v].mask);
         wait_empty("tbl_events", 40);
         btn_in = '0;
         cyc(30);
         check("tbl_release", btn_level, 4'b0000);
      end

      // Simultaneous press with consumer stalled
      do_reset();
      evt_ready = 1'b0;
      btn_in    = 4'b1001;
      push(2'd0);
      push(2'd3);
      wait_valid("t3_valid", 40);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t3_hold_valid", evt_valid, 1);
         check("t3_hold_id", evt_id, 0);
      end
      cyc(1);
      btn_in    = '0;
      evt_ready = 1'b1;
      wait_empty("t3_events", 20);
      cyc(20);

      // rr pointer wrapped back to 0
      btn_in = 4'b0011;
      push(2'd0);
      push(2'd1);
      cyc(30);
      wait_empty("t3_rr0", 20);
      btn_in = '0;
      cyc(20);

      // Fairness: grant 0 leaves rr at 1
      btn_in = 4'b0001;
      push(2'd0);
      cyc(30);
      wait_empty("t4_first", 20);
      btn_in = '0;
      cyc(20);
      btn_in = 4'b0011;
      push(2'd1);
      push(2'd0);
      cyc(30);
      wait_empty("t4_fair", 20);
      btn_in = '0;
      cyc(20);

      // Dropped press while pending
      evt_ready = 1'b0;
      d0 = n_drop;
      btn_in = 4'b0001;
      push(2'd0);
      wait_valid("t5_valid", 40);
      check("t5_id", evt_id, 0);
      cyc(1);
      btn_in = 4'b0010;
      cyc(20);
      check("t5_level1", btn_level, 4'b0010);
      btn_in = '0;
      cyc(20);
      check("t5_level0", btn_level, 4'b0000);
      btn_in = 4'b0010;
      cyc(20);
      check("t5_one_drop", n_drop - d0, 1);
      check("t5_still_valid", evt_valid, 1);
      check("t5_still_id", evt_id, 0);
      push(2'd1);
      evt_ready = 1'b1;
      wait_empty("t5_events", 20);
      btn_in = '0;
      cyc(30);

      // Reset in the middle of an offer
      evt_ready = 1'b0;
      btn_in    = 4'b1100;
      wait_valid("t6_valid", 40);
      cyc(5);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_valid", evt_valid, 0);
      check("t6_id", evt_id, 0);
      check("t6_level", btn_level, 4'b0000);
      btn_in = '0;
      cyc(3);
      rst       = 1'b0;
      evt_ready = 1'b1;
      cyc(100);
      check("t6_no_stale", evt_valid, 0);

      check("total_events", n_evt, n_pushed);
      check("total_drops", n_drop, 1);
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Front-end controller for the board push-buttons. It synchronizes NUM_BTNS asynchronous button inputs through the existing 2-FF synchronizer, then debounces each one with a shared sample timer and per-button saturating counters. It detects debounced rising edges and serializes the resulting press events to the downstream consumer (CPU MMIO / UART command path) over a valid/ready handshake, with round-robin arbitration between buttons.

Parameters:
NUM_BTNS, 4, number of button inputs (≥1)
SAMPLE_CNT_MAX, 25000, clock cycles per debounce sample period (≥3)
PULSE_CNT_MAX, 150, consecutive high samples required to declare a press (≥1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_in  input  NUM_BTNS  raw asynchronous button levels
btn_level  output  NUM_BTNS  debounced button levels
evt_valid  output  1  press event available
evt_ready  input  1  consumer accepts event
evt_id  output  IDW = max(1, clog2(NUM_BTNS))  index of pressed button
evt_dropped  output  1  one-cycle pulse: a press was lost

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (rst). Asserting rst forces all state below to reset values immediately; deassertion is synchronous in effect (first update on the next clk edge).
- Reset values: sample timer 0, all debounce counters 0, btn_level 0, previous-level regs 0, pending 0, rr pointer 0, FSM IDLE, evt_valid 0, evt_id 0, evt_dropped 0.
- Sync stage: a single synchronizer instance (WIDTH=NUM_BTNS) with 2-cycle latency. It has no reset. SAMPLE_CNT_MAX ≥ 3 guarantees no sample is taken before both flop stages are flushed after reset.
- Sample timer: counts 0..SAMPLE_CNT_MAX-1 and wraps to 0. sample_pulse is high for the single cycle in which count == SAMPLE_CNT_MAX-1.
- Debounce counter per button, width clog2(PULSE_CNT_MAX+1):
  - On sample_pulse with synced bit 1: counter increments, saturating at PULSE_CNT_MAX.
  - On sample_pulse with synced bit 0: counter clears to 0.
  - With no sample_pulse: counter holds.
  - btn_level[i] is registered and equals (cnt[i] == PULSE_CNT_MAX), so it updates one cycle after the counter.
- Edge detect: rise[i] = btn_level[i] & ~prev_level[i]. prev_level is registered every cycle. Exactly one rise per debounced press, regardless of hold duration.
- Pending bits, one per button, updated each cycle:
  - Set on rise[i].
  - Cleared when granted.
  - Rise and grant on the same button in the same cycle: set wins, and the button stays pending.
  - rise[i] while pending[i]=1 and not being granted that cycle: pending stays 1 and evt_dropped pulses 1 for one cycle.
- Arbiter FSM:
  - IDLE: if any pending bit is set, grant the first pending index searching upward from rr_ptr with wrap-around. Register that index into evt_id, clear its pending bit, and go to OFFER. evt_valid is high from the next cycle. If nothing is pending, stay in IDLE with evt_valid 0.
  - OFFER: evt_valid = 1, and evt_id is held stable until a handshake. On evt_valid & evt_ready: rr_ptr ← (evt_id+1) mod NUM_BTNS, go to IDLE, and evt_valid is 0 next cycle.
  - evt_ready is ignored in IDLE.
  - Maximum throughput is one event per 2 cycles.
- Latency, for a clean held press: btn_level rises on the cycle after the PULSE_CNT_MAX-th consecutive high sample_pulse. pending is set 1 cycle later. evt_valid is set 1 cycle after that if the FSM is IDLE.
- Release does not generate an event. btn_level falls one cycle after the first low sample.
- Reset mid-OFFER: evt_valid drops asynchronously and the in-flight event is discarded.

Test Plan:
(Bench parameters: NUM_BTNS=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.)
1. Hold btn_in[2]=1 from reset, evt_ready=1 → btn_level[2] rises after the 3rd sample_pulse. Exactly one handshake occurs with evt_id=2. No further events while held for 100 cycles. Release → btn_level[2]=0, no event.
2. Glitch: btn_in[1] high across 2 sample_pulses, then low → cnt[1] returns to 0. btn_level[1] and evt_valid stay 0.
3. btn_in[0] and btn_in[3] pressed together, evt_ready=0 for 20 cycles → evt_valid=1 with evt_id=0, held stable. Then evt_ready=1 → handshakes in order id 0, then id 3. Final rr_ptr=0.
4. Fairness: rr_ptr=1 after granting 0, then buttons 0 and 1 pend simultaneously → id 1 granted before id 0.
5. Drop: id 0 held in OFFER with evt_ready=0. btn 1 pressed, released, and pressed again → evt_dropped pulses exactly once. After ready, exactly one id-1 event follows.
6. Assert rst during OFFER with pending bits set → evt_valid=0, evt_id=0 and btn_level=0 immediately. After release, no stale events appear.
